fixed3_inv_responder: RTL and testbench
=======================================

Name: fixed3_inv_responder

Overview:
- Iterative responder for the Fixed3 reciprocal strobe/valid protocol used by the shadowing-ray and primary-ray generators.
- Accepts a Fixed3 direction vector on a one-cycle strobe and computes 1/x, 1/y and 1/z with three parallel restoring dividers.
- Returns the inverse-direction vector with a one-cycle valid pulse.
- Sits beside each ray generator as the slab-test InvDir source.

Parameters:
- WIDTH, 32, bit width of one Fixed component (two's complement).
- FRAC, 16, fractional bits of Fixed; ITER = 2*FRAC+1 division iterations (33 by default).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- strobe  input  1  start request; sampled only in IDLE
- v  input  3*WIDTH  Fixed3 operand, packed x=[3W-1:2W], y=[2W-1:W], z=[W-1:0]
- busy  output  1  high while not in IDLE
- valid  output  1  one-cycle pulse, ov holds a new result
- ov  output  3*WIDTH  Fixed3 reciprocal, same packing as v
- div_zero  output  3  per-component flag (bit2=x, bit1=y, bit0=z); operand was exactly zero; valid with ov

Behaviour:
- Reset (reset=1 at a rising edge) forces the following, regardless of the current state, and abandons any in-flight division:
  - state=IDLE, busy=0, valid=0, ov=0, div_zero=0.
  - Iteration counter and remainder/quotient registers cleared.
- States: IDLE -> DIV -> FIX -> IDLE.
- IDLE:
  - On strobe=1, capture v.
  - Per component, store sign and unsigned magnitude |c|. |-2^(W-1)| = 2^(W-1) fits in W unsigned bits.
  - Load dividend = 2^(2*FRAC) (ITER bits), clear the remainder, counter=0, go to DIV.
- DIV: one restoring-division step per cycle per component, MSB of dividend first:
  - rem = {rem, next dividend bit}.
  - If rem >= |c|: rem -= |c| and shift 1 into the quotient; else shift 0.
  - Quotient register is ITER bits wide.
  - After ITER steps (counter == ITER-1), go to FIX.
- FIX, per component, in one cycle:
  - |c|==0: result = +(2^(W-1)-1) if the sign is positive (zero is positive); set div_zero bit.
  - Quotient > 2^(W-1)-1: saturate to +(2^(W-1)-1), or -(2^(W-1)-1) if negative. Symmetric; never 0x80000000.
  - Otherwise result = quotient, negated if the sign is negative. Truncation toward zero.
  - Register ov and div_zero, set valid=1, go to IDLE.
- valid:
  - High exactly one cycle (the cycle after the FIX edge).
  - Deasserted by the next edge unconditionally; there is no downstream backpressure.
- ov and div_zero hold their value until the next FIX; they are not cleared on return to IDLE.
- Latency: strobe sampled at edge E0 gives valid=1 in the cycle following edge E0+ITER+1, i.e. ITER+2 cycles (35 by default).
- busy=1 from the cycle after the accepting edge until the cycle valid rises; busy=0 in the valid cycle.
- strobe while busy: ignored, no queuing; v changes while busy have no effect.
- strobe in the same cycle valid is high (state=IDLE): accepted, back-to-back throughput one result per ITER+2 cycles.
- reset and strobe in the same cycle: reset wins, the request is dropped.
- Arithmetic is fully unsigned inside DIV. Sign is applied only in FIX. Remainder width W+1 bits so the compare does not overflow.

Test Plan:
- Reset mid-DIV (assert reset 10 cycles after strobe), then strobe v=(2.0,2.0,2.0):
  - After reset: valid never pulses for the aborted request, busy=0, ov=0.
  - New request: ov=(0x00008000)x3 at exactly 35 cycles.
- strobe v=(1.0,2.0,-4.0)=(0x00010000,0x00020000,0xFFFC0000):
  - valid 35 cycles later, one cycle wide.
  - ov=(0x00010000,0x00008000,0xFFFFC000), div_zero=000.
- strobe v=(0,0x00000001,0xFFFFFFFF):
  - ov=(0x7FFFFFFF,0x7FFFFFFF,0x80000001), div_zero=100.
- strobe v=(3.0,-3.0,0x80000000):
  - ov=(0x00005555,0xFFFFAAAB,0xFFFFFFFE), div_zero=000.
- Strobe pulses 5 and 20 cycles into a busy period with different v:
  - Exactly one valid, carrying the first operand's result.
  - Strobe held high continuously from the valid cycle: next valid exactly 35 cycles later.

Source files
------------

// File: rtl/fixed3_inv_responder.sv
// Fixed3 reciprocal responder: three parallel restoring dividers
// producing 1/x, 1/y, 1/z with symmetric saturation.
module fixed3_inv_responder #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               strobe,
    input  logic [3*WIDTH-1:0] v,
    output logic               busy,
    output logic               valid,
    output logic [3*WIDTH-1:0] ov,
    output logic [2:0]         div_zero
);

    localparam int ITER = 2*FRAC + 1;
    localparam int CW   = $clog2(ITER);
    localparam logic [WIDTH-1:0] SAT = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ITER-1:0]    dvd_q, dvd_d;
    logic [2:0]         sign_q, sign_d;
    logic [WIDTH-1:0]   mag_q [3];
    logic [WIDTH-1:0]   mag_d [3];
    logic [WIDTH:0]     rem_q [3];
    logic [WIDTH:0]     rem_d [3];
    logic [ITER-1:0]    quo_q [3];
    logic [ITER-1:0]    quo_d [3];
    logic [3*WIDTH-1:0] ov_q, ov_d;
    logic [2:0]         dz_q, dz_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   comp;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH-1:0]   res;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        ov_d    = ov_q;
        dz_d    = dz_q;
        valid_d = 1'b0;
        comp    = '0;
        trial   = '0;
        res     = '0;
        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    for (int k = 0; k < 3; k++) begin
                        comp      = v[k*WIDTH +: WIDTH];
                        sign_d[k] = comp[WIDTH-1];
                        mag_d[k]  = comp[WIDTH-1] ? -comp : comp;
                        rem_d[k]  = '0;
                        quo_d[k]  = '0;
                    end
                    dvd_d   = {1'b1, {(ITER-1){1'b0}}};
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                // Dividend is shared: every lane divides 2^(2*FRAC).
                for (int k = 0; k < 3; k++) begin
                    trial = {rem_q[k], dvd_q[ITER-1]};
                    if (trial >= {2'b00, mag_q[k]}) begin
                        rem_d[k] = (WIDTH+1)'(trial - {2'b00, mag_q[k]});
                        quo_d[k] = {quo_q[k][ITER-2:0], 1'b1};
                    end else begin
                        rem_d[k] = (WIDTH+1)'(trial);
                        quo_d[k] = {quo_q[k][ITER-2:0], 1'b0};
                    end
                end
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                for (int k = 0; k < 3; k++) begin
                    dz_d[k] = 1'b0;
                    if (mag_q[k] == '0) begin
                        res     = SAT;
                        dz_d[k] = 1'b1;
                    end else if (quo_q[k] > ITER'(SAT)) begin
                        res = sign_q[k] ? -SAT : SAT;
                    end else begin
                        res = quo_q[k][WIDTH-1:0];
                        if (sign_q[k]) begin
                            res = -res;
                        end
                    end
                    ov_d[k*WIDTH +: WIDTH] = res;
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            sign_q  <= '0;
            ov_q    <= '0;
            dz_q    <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                mag_q[k] <= '0;
                rem_q[k] <= '0;
                quo_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            sign_q  <= sign_d;
            ov_q    <= ov_d;
            dz_q    <= dz_d;
            valid_q <= valid_d;
            for (int k = 0; k < 3; k++) begin
                mag_q[k] <= mag_d[k];
                rem_q[k] <= rem_d[k];
                quo_q[k] <= quo_d[k];
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign valid    = valid_q;
    assign ov       = ov_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_fixed3_inv_responder.sv
// Randomized bench for fixed3_inv_responder against an arithmetic
// reciprocal model.
module tb_fixed3_inv_responder;

    localparam int W   = 32;
    localparam int LAT = 35;

    logic          clk = 1'b0;
    logic          reset;
    logic          strobe;
    logic [3*W-1:0] v;
    logic          busy;
    logic          valid;
    logic [3*W-1:0] ov;
    logic [2:0]    div_zero;

    int errors = 0;
    int checks = 0;

    fixed3_inv_responder dut (
        .clk      (clk),
        .reset    (reset),
        .strobe   (strobe),
        .v        (v),
        .busy     (busy),
        .valid    (valid),
        .ov       (ov),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3*W-1:0] got,
                         input logic [3*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] inv1(input logic [W-1:0] c,
                                          output bit dz);
        longint sc, mag, q, mx, r;
        sc = longint'($signed(c));
        mx = (longint'(1) << (W-1)) - 1;
        mag = (sc < 0) ? -sc : sc;
        dz = (mag == 0);
        if (mag == 0) return mx[W-1:0];
        q = (longint'(1) << 32) / mag;
        if (q > mx) q = mx;
        r = (sc < 0) ? -q : q;
        return r[W-1:0];
    endfunction

    function automatic logic [3*W-1:0] model(input logic [3*W-1:0] vin,
                                             output logic [2:0] dz);
        logic [3*W-1:0] o;
        bit d;
        for (int k = 0; k < 3; k++) begin
            o[k*W +: W] = inv1(vin[k*W +: W], d);
            dz[k] = d;
        end
        return o;
    endfunction

    function automatic logic [W-1:0] rnd_comp();
        logic [W-1:0] c;
        case ($urandom_range(0, 5))
            0: c = '0;
            1: c = 32'h8000_0000;
            2: c = 32'($urandom_range(1, 8));
            3: c = 32'($urandom_range(1, 9)) << 16;
            default: c = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) c = -c;
        return c;
    endfunction

    // Entered just after a negedge with strobe=1 and v=vin driven.
    task automatic collect(input logic [3*W-1:0] vin, input string tag,
                           input bit noise, input bit hold,
                           input logic [3*W-1:0] vnext);
        int nval = 0;
        int lat = 0;
        logic [3*W-1:0] exp;
        logic [2:0] edz;
        exp = model(vin, edz);
        for (int n = 1; n <= 58; n++) begin
            @(negedge clk);
            if (n == 1) check({tag, "_busy"}, 96'(busy), 96'(1));
            if (valid) begin
                nval++;
                if (nval == 1) begin
                    lat = n;
                    check({tag, "_ov"}, ov, exp);
                    check({tag, "_dz"}, 96'(div_zero), 96'(edz));
                    check({tag, "_busy_valid"}, 96'(busy), 96'(0));
                end
                if (hold) begin
                    v = vnext;
                    break;
                end
            end
            if (!hold) begin
                strobe = noise && (n == 5 || n == 20);
                v = {$urandom, $urandom, $urandom};
            end
        end
        check({tag, "_lat"}, 96'(lat), 96'(LAT));
        if (!hold) check({tag, "_nvalid"}, 96'(nval), 96'(1));
    endtask

    task automatic request(input logic [3*W-1:0] vin, input string tag,
                           input bit noise);
        strobe = 1'b1;
        v = vin;
        collect(vin, tag, noise, 1'b0, '0);
    endtask

    initial begin
        int nval;
        logic [3*W-1:0] va, vb;
        reset = 1'b1;
        strobe = 1'b0;
        v = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_valid", 96'(valid), 96'(0));
        check("rst_ov", ov, '0);
        check("rst_dz", 96'(div_zero), 96'(0));
        reset = 1'b0;

        @(negedge clk);
        strobe = 1'b1;
        v = {32'h0002_0000, 32'h0002_0000, 32'h0002_0000};
        @(negedge clk);
        strobe = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        strobe = 1'b1;
        v = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        @(negedge clk);
        reset = 1'b0;
        strobe = 1'b0;
        check("abort_busy", 96'(busy), 96'(0));
        check("abort_valid", 96'(valid), 96'(0));
        check("abort_ov", ov, '0);
        nval = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) nval++;
        end
        check("abort_nvalid", 96'(nval), 96'(0));
        check("abort_idle", 96'(busy), 96'(0));

        request({32'h0002_0000, 32'h0002_0000, 32'h0002_0000}, "two", 0);
        check("two_const", ov, {3{32'h0000_8000}});

        request({32'h0001_0000, 32'h0002_0000, 32'hFFFC_0000}, "mix", 0);
        check("mix_const", ov, {32'h0001_0000, 32'h0000_8000, 32'hFFFF_C000});

        request({32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF}, "sat", 0);
        check("sat_const", ov, {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0001});
        check("sat_dz", 96'(div_zero), 96'(3'b100));

        request({32'h0003_0000, 32'hFFFD_0000, 32'h8000_0000}, "thr", 0);
        check("thr_const", ov, {32'h0000_5555, 32'hFFFF_AAAB, 32'hFFFF_FFFE});

        request({32'h0004_0000, 32'h0000_0003, 32'hFFFF_0000}, "noise", 1);

        va = {rnd_comp(), rnd_comp(), rnd_comp()};
        vb = {rnd_comp(), rnd_comp(), rnd_comp()};
        strobe = 1'b1;
        v = va;
        collect(va, "b2b_a", 0, 1, vb);
        collect(vb, "b2b_b", 0, 0, '0);

        for (int i = 0; i < 20; i++) begin
            va = {rnd_comp(), rnd_comp(), rnd_comp()};
            request(va, $sformatf("rnd%0d", i), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
